// File: rtl/ram_pkg.sv
// Shared memory-map constants and control state encoding
// for the on-chip memory blocks.
package ram_pkg;

  localparam logic [15:0] RAM_BOUND_L = 16'h0200;
  localparam logic [15:0] RAM_BOUND_U = 16'h0A00;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ram_state_t;

  typedef struct packed {
    logic [1:0]  lane;
    logic [15:0] data;
  } ram_wr_t;

  function automatic logic addr_in_range(
    input logic [15:0] addr,
    input logic [15:0] lo,
    input logic [15:0] hi
  );
    return (addr >= lo) && (addr < hi);
  endfunction

endpackage

// File: rtl/ram.sv
// Word-organised data RAM with byte lanes, power-on clearing
// and a sticky out-of-range write flag.
module ram
  import ram_pkg::*;
#(
  parameter logic [15:0] BOUND_L = RAM_BOUND_L,
  parameter logic [15:0] BOUND_U = RAM_BOUND_U
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ram_addr,
  input  logic [15:0] ram_in,
  input  logic        BW,
  input  logic        MW,
  output logic [15:0] ram_out,
  output logic        ready,
  output logic        err
);

  localparam int SIZE = int'(BOUND_U - BOUND_L) / 2;
  localparam int IW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IW-1:0] LAST = IW'(SIZE - 1);

  ram_state_t    state_q, state_d;
  logic [IW-1:0] clr_q, clr_d;

  logic [15:0]   mem [SIZE];

  logic          hit;
  logic [15:0]   off;
  logic [14:0]   widx;
  logic [IW-1:0] idx;
  logic [15:0]   word;

  logic          we;
  logic [IW-1:0] wr_idx;
  ram_wr_t       wr;

  // range check first; the subtraction is only used when hit
  assign hit  = addr_in_range(ram_addr, BOUND_L, BOUND_U);
  assign off  = ram_addr - BOUND_L;
  assign widx = off[15:1];
  assign idx  = widx[IW-1:0];
  assign word = mem[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    unique case (state_q)
      ST_INIT: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == LAST) begin
          state_d = ST_RUN;
          clr_d   = '0;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
        clr_d   = '0;
      end
    endcase
  end

  assign ready = (state_q == ST_RUN);

  always_comb begin
    we      = 1'b0;
    wr_idx  = idx;
    wr.lane = 2'b11;
    wr.data = ram_in;
    if (state_q == ST_INIT) begin
      we      = ~rst;
      wr_idx  = clr_q;
      wr.data = 16'h0000;
    end else if (MW && hit) begin
      we = 1'b1;
      if (BW) begin
        wr.lane = ram_addr[0] ? 2'b10 : 2'b01;
        wr.data = {ram_in[7:0], ram_in[7:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      if (wr.lane[0]) mem[wr_idx][7:0]  <= wr.data[7:0];
      if (wr.lane[1]) mem[wr_idx][15:8] <= wr.data[15:8];
    end
  end

  always_comb begin
    ram_out = 16'h0000;
    if (state_q == ST_RUN && hit) begin
      if (BW) ram_out = {8'h00, ram_addr[0] ? word[15:8] : word[7:0]};
      else    ram_out = word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  err <= 1'b0;
    else if (state_q == ST_RUN && MW && !hit) err <= 1'b1;
  end

endmodule

// File: tb/tb_ram.sv
// Directed checks of the data RAM: clearing, word/byte access,
// range errors, read-before-write timing and async reset.
module tb_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ram_addr = 16'h0200;
  logic [15:0] ram_in = 16'h0000;
  logic        BW = 1'b0;
  logic        MW = 1'b0;
  logic [15:0] ram_out;
  logic        ready;
  logic        err;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  ram dut (
    .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_in(ram_in),
    .BW(BW), .MW(MW), .ram_out(ram_out), .ready(ready), .err(err)
  );

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d,
                    input logic b);
    @(negedge clk);
    ram_addr = a; ram_in = d; BW = b; MW = 1'b1;
    @(posedge clk);
    #1 MW = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a,
                    input logic b, input logic [15:0] exp);
    @(negedge clk);
    ram_addr = a; BW = b; MW = 1'b0;
    #1 check(tag, ram_out, exp);
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 3000) begin
      @(posedge clk);
      #1 cnt++;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", {15'd0, ready}, 16'd0);
    check("rst_err", {15'd0, err}, 16'd0);
    check("rst_out", ram_out, 16'h0000);

    // scenario 1: MW held high throughout clearing
    ram_addr = 16'h0200; ram_in = 16'hFFFF; BW = 1'b0; MW = 1'b1;
    rst = 1'b0;
    wait_ready(n);
    check("init_len", 16'(n), 16'd1024);
    check("init_err", {15'd0, err}, 16'd0);
    MW = 1'b0;
    rd("init_rd", 16'h0200, 1'b0, 16'h0000);

    // scenario 2
    wr(16'h0200, 16'hBEEF, 1'b0);
    rd("word_rd_odd", 16'h0201, 1'b0, 16'hBEEF);

    // scenario 3
    wr(16'h0300, 16'h0012, 1'b1);
    wr(16'h0301, 16'hFF34, 1'b1);
    rd("byte_word", 16'h0300, 1'b0, 16'h3412);
    rd("byte_hi", 16'h0301, 1'b1, 16'h0034);
    rd("byte_lo", 16'h0300, 1'b1, 16'h0012);

    // scenario 4
    check("pre_err", {15'd0, err}, 16'd0);
    wr(16'h0A00, 16'h1234, 1'b0);
    check("err_hi_wr", {15'd0, err}, 16'd1);
    wr(16'h01FE, 16'h5678, 1'b0);
    check("err_sticky", {15'd0, err}, 16'd1);
    rd("oor_rd_hi", 16'h0A00, 1'b0, 16'h0000);
    rd("oor_rd_lo", 16'h01FF, 1'b0, 16'h0000);
    rd("word0_keep", 16'h0200, 1'b0, 16'hBEEF);
    rd("word1023_keep", 16'h09FE, 1'b0, 16'h0000);

    // scenario 5: no write bypass
    @(negedge clk);
    ram_addr = 16'h09FE; ram_in = 16'hAAAA; BW = 1'b0; MW = 1'b1;
    @(posedge clk);
    #1 ram_in = 16'h5555;
    #1 check("rbw_old", ram_out, 16'hAAAA);
    @(posedge clk);
    #1 MW = 1'b0;
    #1 check("rbw_new", ram_out, 16'h5555);
    rd("last_byte_hi", 16'h09FF, 1'b1, 16'h0055);

    // async reset during RUN
    @(negedge clk);
    ram_addr = 16'h09FE; BW = 1'b0;
    #2 rst = 1'b1;
    #1 check("run_rst_ready", {15'd0, ready}, 16'd0);
    check("run_rst_err", {15'd0, err}, 16'd0);
    check("run_rst_out", ram_out, 16'h0000);

    // scenario 6: reset at INIT cycle 500
    @(negedge clk);
    rst = 1'b0;
    repeat (500) @(posedge clk);
    #1 check("mid_init_ready", {15'd0, ready}, 16'd0);
    wr(16'h0A00, 16'h0001, 1'b0);
    check("init_no_err", {15'd0, err}, 16'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("init_rst_ready", {15'd0, ready}, 16'd0);
    check("init_rst_err", {15'd0, err}, 16'd0);
    check("init_rst_out", ram_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    check("reinit_len", 16'(n), 16'd1024);
    rd("reinit_clear", 16'h09FE, 1'b0, 16'h0000);
    wr(16'h0400, 16'hC0DE, 1'b0);
    rd("post_wr", 16'h0400, 1'b0, 16'hC0DE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001 Parameter BOUND_L, default 16'h0200, is the lowest byte address decoded by the RAM.
REQ-002 Parameter BOUND_U, default 16'h0A00, is the exclusive upper byte address; SIZE = (BOUND_U-BOUND_L)/2 words (1024 by default).
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, reset, asynchronous and active-high.
REQ-005 Port ram_addr, input, 16, byte address of the access.
REQ-006 Port ram_in, input, 16, write data; byte writes use bits [7:0].
REQ-007 Port BW, input, 1, 1 = byte access, 0 = word access.
REQ-008 Port MW, input, 1, write strobe; one write per cycle while high.
REQ-009 Port ram_out, output, 16, read data.
REQ-010 Port ready, output, 1, high once power-on clearing is complete.
REQ-011 Port err, output, 1, sticky flag for an out-of-range write.

Function
REQ-012 Control FSM states: INIT (clearing) and RUN; reset enters INIT with clear index 0.
REQ-013 INIT writes 16'h0000 to word[index] each cycle and increments index; after word SIZE-1 is written the FSM enters RUN; INIT lasts exactly SIZE cycles.
REQ-014 ready = 1 only in RUN; RUN is held until reset.
REQ-015 Word index = (ram_addr - BOUND_L) >> 1; an address is in range when BOUND_L <= ram_addr < BOUND_U.
REQ-016 Word write (BW=0, MW=1, RUN, in range): word[index] <= ram_in on the clock edge; ram_addr[0] is ignored.
REQ-017 Byte write (BW=1): ram_in[7:0] goes to the low lane when ram_addr[0]=0 and to the high lane when ram_addr[0]=1; the other lane is unchanged.
REQ-018 Read is combinational: word access returns word[index]; byte access returns {8'h00, selected lane}.
REQ-019 Write and read to the same address in one cycle: ram_out shows the old data until the edge and the new data afterwards; there is no bypass.
REQ-020 Out-of-range access: ram_out = 16'h0000; a write with MW=1 is dropped and sets err on that edge.
REQ-021 In INIT: MW is ignored, err is not set, and ram_out = 16'h0000.
REQ-022 Wrap-around is not permitted: index arithmetic is done only after the range check, so addresses below BOUND_L never alias.

Reset
REQ-023 Reset values: ready=0, err=0, ram_out=16'h0000, FSM=INIT, clear index=0.
REQ-024 Reset asserted mid-INIT or mid-RUN aborts the current operation and restarts clearing from index 0; memory contents are not guaranteed until ready rises again.
REQ-025 err is cleared only by rst.

Structure
REQ-026 The FSM state encoding and the default BOUND_L/BOUND_U memory-map constants belong in the shared package used by the other memory blocks.
REQ-027 No sub-module is required; the storage array is inferred inside ram.

Verification
REQ-028 Scenario 1: release rst, hold MW=1 -> ready low for exactly 1024 cycles then high; memory is unchanged by MW; a read of 16'h0200 gives 16'h0000.
REQ-029 Scenario 2: word write 16'hBEEF at 16'h0200, then word read at 16'h0201 -> ram_out = 16'hBEEF.
REQ-030 Scenario 3: byte write 8'h12 at 16'h0300, then 8'h34 at 16'h0301; word read 16'h0300 -> 16'h3412; byte read 16'h0301 -> 16'h0034.
REQ-031 Scenario 4: word write at 16'h0A00 and at 16'h01FE -> err rises after the first write and stays high; a read of 16'h0A00 gives 16'h0000; words 0 and 1023 are unchanged.
REQ-032 Scenario 5: write 16'hAAAA then 16'h5555 to 16'h09FE on consecutive cycles -> ram_out shows 16'hAAAA in the cycle of the second write and 16'h5555 after it.
REQ-033 Scenario 6: assert rst at INIT cycle 500 -> ready, err and ram_out are 0 immediately; after release, ready rises 1024 cycles later.
